board_updater: RTL

BOARD_UPDATER -- requirements
Module: board_updater

---
 rtl/board_updater.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/board_updater.sv
// Places a stone for the player to move (or clears the board) by read-modify-write
// over a single-port style memory interface with a combinational read path.
module board_updater #(
    parameter int SIZE          = 16,
    parameter int DEPTH         = 64,
    parameter int PLAYER0_START = 1,
    parameter int PLAYER1_START = 10,
    parameter int TURN_ADDR     = 28,
    parameter int ROWS          = 9,
    parameter int COLS          = 9,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            place_valid,
    input  logic [3:0]      place_row,
    input  logic [3:0]      place_col,
    output logic            place_ready,
    input  logic            clear_req,
    output logic [AW-1:0]   raddr,
    input  logic [SIZE-1:0] read_data,
    output logic [AW-1:0]   waddr,
    output logic [SIZE-1:0] write_data,
    output logic            write_en,
    output logic            done,
    output logic            accepted,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_TURN = 3'd1,
        RD_P0   = 3'd2,
        RD_P1   = 3'd3,
        WR_CELL = 3'd4,
        WR_TURN = 3'd5,
        CLEAR   = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam logic [AW-1:0] P0_A   = AW'(PLAYER0_START);
    localparam logic [AW-1:0] P1_A   = AW'(PLAYER1_START);
    localparam logic [AW-1:0] TURN_A = AW'(TURN_ADDR);

    state_t          state, state_n;
    logic [AW-1:0]   cnt;
    logic [SIZE-1:0] turn_q, w0, w1;
    logic [3:0]      row_q, col_q;
    logic            acc_q;
    logic            bad_coord;
    logic            occupied;
    logic [SIZE-1:0] col_mask;

    // Handshake: a place request transfers on a clk edge where place_valid && place_ready;
    // place_row/place_col must be stable with place_valid, and the request is consumed once.
    assign bad_coord = (32'(place_row) >= ROWS) || (32'(place_col) >= COLS);
    assign col_mask  = SIZE'(1) << col_q;
    // In RD_P1 the player-1 word is still on read_data, so test it before it lands in w1.
    assign occupied  = ((w0 | read_data) & col_mask) != '0;
    assign dbg_state = state;
    assign accepted  = acc_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (clear_req)        state_n = CLEAR;
                else if (place_valid) state_n = bad_coord ? DONE : RD_TURN;
            end
            RD_TURN: state_n = RD_P0;
            RD_P0:   state_n = RD_P1;
            RD_P1:   state_n = occupied ? DONE : WR_CELL;
            WR_CELL: state_n = WR_TURN;
            WR_TURN: state_n = DONE;
            CLEAR:   state_n = (cnt == TURN_A) ? DONE : CLEAR;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        place_ready = 1'b0;
        raddr       = TURN_A;
        waddr       = '0;
        write_data  = '0;
        write_en    = 1'b0;
        done        = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:  place_ready = !clear_req;
                RD_P0: raddr = P0_A + AW'(row_q);
                RD_P1: raddr = P1_A + AW'(row_q);
                WR_CELL: begin
                    write_en   = 1'b1;
                    waddr      = (turn_q[0] ? P1_A : P0_A) + AW'(row_q);
                    write_data = (turn_q[0] ? w1 : w0) | col_mask;
                end
                WR_TURN: begin
                    write_en   = 1'b1;
                    waddr      = TURN_A;
                    write_data = turn_q ^ SIZE'(1);
                end
                CLEAR: begin
                    write_en = 1'b1;
                    waddr    = cnt;
                end
                DONE:    done = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            turn_q <= '0;
            w0     <= '0;
            w1     <= '0;
            row_q  <= '0;
            col_q  <= '0;
            acc_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        cnt <= P0_A;
                    end else if (place_valid) begin
                        row_q <= place_row;
                        col_q <= place_col;
                        if (bad_coord) acc_q <= 1'b0;
                    end
                end
                RD_TURN: turn_q <= read_data;
                RD_P0:   w0 <= read_data;
                RD_P1: begin
                    w1 <= read_data;
                    if (occupied) acc_q <= 1'b0;
                end
                WR_TURN: acc_q <= 1'b1;
                CLEAR: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == TURN_A) acc_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
